// File: rtl/mux8_pkg.sv
// Shared constants, state type and round-robin pick function for the 8-channel
// bit-mux scheduler.
package mux8_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_t;

    // Returns {found, idx}: first requesting channel scanning ptr, ptr+1, ... (mod 8).
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [SEL_W-1:0]  ptr);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// Plain 8:1 single-bit multiplexer shared by all requesters.
module mux_8x1
    import mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] i,
    input  logic [SEL_W-1:0]  s,
    output logic              y
);

    always_comb begin
        y = i[s];
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler granting one of 8 requesters the shared bit mux and
// streaming the granted bit over a valid/ready handshake.
module mux8_rr_scheduler
    import mux8_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] i,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  s,
    output logic              y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy
);

    localparam int unsigned      CNT_W     = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t            state_q;
    logic [NUM_CH-1:0] gnt_q;
    logic [SEL_W-1:0]  s_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              mux_bit;
    logic              fire;
    logic              release_now;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W:0]    pick;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [NUM_CH-1:0] pick_oh;

    mux_8x1 u_mux (
        .i (i),
        .s (s_q),
        .y (mux_bit)
    );

    always_comb begin
        busy        = (state_q == StBusy);
        y_valid     = busy && req[s_q];
        y           = y_valid & mux_bit;
        fire        = y_valid && y_ready;
        release_now = busy && (!req[s_q] || (fire && (cnt_q == LAST_BEAT)));
        // On release the search restarts just past the channel being released.
        pick_ptr    = busy ? (s_q + SEL_W'(1)) : ptr_q;
        pick        = rr_pick(req, pick_ptr);
        pick_found  = pick[SEL_W];
        pick_idx    = pick[SEL_W-1:0];
        pick_oh     = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    assign gnt = gnt_q;
    assign s   = s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            s_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en && pick_found) begin
                        state_q <= StBusy;
                        gnt_q   <= pick_oh;
                        s_q     <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        ptr_q <= pick_ptr;
                        if (en && pick_found) begin
                            gnt_q <= pick_oh;
                            s_q   <= pick_idx;
                            cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                        end
                    end else if (fire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Self-checking bench for mux8_rr_scheduler: directed scenarios plus a randomized
// run checked against an integer-level round-robin reference model.
module tb_mux8_rr_scheduler;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       y_ready;
    logic       y;
    logic       y_valid;
    logic       busy;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] s;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who holds the mux, beats taken, where the next search starts.
    bit m_busy;
    int m_ch;
    int m_ptr;
    int m_cnt;

    mux8_rr_scheduler #(.MAX_BEATS(MAXB)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .i       (i),
        .gnt     (gnt),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8] === 1'b1) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        return m_busy ? 8'(1 << m_ch) : 8'h00;
    endfunction

    function automatic logic exp_yv();
        return m_busy && (req[m_ch] === 1'b1);
    endfunction

    function automatic logic exp_y();
        return exp_yv() ? i[m_ch] : 1'b0;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_ch   = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    // Advance one clock; the model takes its step from the inputs seen before the edge.
    task automatic tick();
        bit nb;
        int nc, np, nn, k;
        bit beat;
        nb = m_busy; nc = m_ch; np = m_ptr; nn = m_cnt;
        if (rst !== 1'b1) begin
            if (!m_busy) begin
                k = pick(req, m_ptr);
                if (en && k >= 0) begin nb = 1'b1; nc = k; nn = 0; end
            end else begin
                beat = (req[m_ch] === 1'b1) && (y_ready === 1'b1);
                if (req[m_ch] !== 1'b1 || (beat && m_cnt == MAXB - 1)) begin
                    np = (m_ch + 1) % 8;
                    k  = pick(req, np);
                    if (en && k >= 0) begin nc = k; nn = 0; end
                    else nb = 1'b0;
                end else if (beat) begin
                    nn = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        m_busy = nb; m_ch = nc; m_ptr = np; m_cnt = nn;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 8'hFF; i = 8'hFF; y_ready = 1'b1;
        model_reset();
        #2;
        n_cmp++; if (gnt !== 8'h00) begin n_bad++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        n_cmp++; if (s !== 3'd0) begin n_bad++; $display("FAIL reset_s: got %0d want 0", s); end
        n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL reset_yv: got %b want 0", y_valid); end
        n_cmp++; if (y !== 1'b0) begin n_bad++; $display("FAIL reset_y: got %b want 0", y); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        n_cmp++; if (gnt !== 8'h00 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_held: gnt=%h busy=%b want 00/0", gnt, busy);
        end
        req = 8'h00;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_idle();
        en = 1'b1; req = 8'h00; y_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            i = 8'($urandom);
            tick();
            n_cmp++; if (gnt !== 8'h00 || y_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL idle_c%0d: gnt=%h yv=%b busy=%b want 00/0/0", c, gnt, y_valid, busy);
            end
        end
        req = 8'h40;
        tick();
        n_cmp++; if (gnt !== 8'h40) begin n_bad++; $display("FAIL idle_grant_gnt: got %h want 40", gnt); end
        n_cmp++; if (s !== 3'd6) begin n_bad++; $display("FAIL idle_grant_s: got %0d want 6", s); end
        n_cmp++; if (busy !== 1'b1 || y_valid !== 1'b1) begin
            n_bad++; $display("FAIL idle_grant_busy: busy=%b yv=%b want 1/1", busy, y_valid);
        end
        req = 8'h00;
        #1;
        n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL idle_drop_yv: got %b want 0", y_valid); end
        tick();
        n_cmp++; if (busy !== 1'b0 || gnt !== 8'h00) begin
            n_bad++; $display("FAIL idle_release: busy=%b gnt=%h want 0/00", busy, gnt);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        en = 1'b1; y_ready = 1'b1; req = 8'h08;
        tick();
        n_cmp++; if (gnt !== 8'h08) begin n_bad++; $display("FAIL rmid_grant: got %h want 08", gnt); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (gnt !== 8'h00 || y_valid !== 1'b0 || y !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmid_async: gnt=%h yv=%b y=%b busy=%b want 00/0/0/0", gnt, y_valid, y, busy);
        end
        rst = 1'b0;
        #1;
        tick();
        n_cmp++; if (gnt !== 8'h08 || s !== 3'd3) begin
            n_bad++; $display("FAIL rmid_regrant: gnt=%h s=%0d want 08/3", gnt, s);
        end
        // A second requester exposes whether the beat count restarted from zero.
        req = 8'h18;
        for (int b = 0; b < MAXB; b++) begin
            n_cmp++; if (gnt !== 8'h08) begin n_bad++; $display("FAIL rmid_beat%0d: gnt=%h want 08", b, gnt); end
            tick();
        end
        n_cmp++; if (gnt !== 8'h10) begin n_bad++; $display("FAIL rmid_rotate: gnt=%h want 10", gnt); end
    endtask

    task automatic test_rotation();
        int ch;
        do_reset();
        en = 1'b1; y_ready = 1'b1; req = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++) begin
            ch = g % 8;
            for (int b = 0; b < MAXB; b++) begin
                i = 8'($urandom);
                #1;
                n_cmp++; if (gnt !== 8'(1 << ch) || s !== 3'(ch) || busy !== 1'b1) begin
                    n_bad++; $display("FAIL rot_g%0d_b%0d: gnt=%h s=%0d busy=%b want %h/%0d/1", g, b, gnt, s, busy, 8'(1 << ch), ch);
                end
                n_cmp++; if (y_valid !== 1'b1 || y !== i[ch]) begin
                    n_bad++; $display("FAIL rot_y_g%0d_b%0d: yv=%b y=%b want 1/%b", g, b, y_valid, y, i[ch]);
                end
                tick();
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; y_ready = 1'b0; req = 8'h20;
        tick();
        req = 8'h21;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (gnt !== 8'h20 || y_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold_c%0d: gnt=%h yv=%b want 20/1", c, gnt, y_valid);
            end
            tick();
        end
        y_ready = 1'b1;
        for (int b = 0; b < MAXB; b++) begin
            n_cmp++; if (gnt !== 8'h20) begin n_bad++; $display("FAIL bp_beat%0d: gnt=%h want 20", b, gnt); end
            tick();
        end
        n_cmp++; if (gnt !== 8'h01 || s !== 3'd0) begin
            n_bad++; $display("FAIL bp_rotate: gnt=%h s=%0d want 01/0", gnt, s);
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        en = 1'b1; y_ready = 1'b1; req = 8'h04;
        tick();
        n_cmp++; if (gnt !== 8'h04 || y_valid !== 1'b1) begin
            n_bad++; $display("FAIL ed_grant: gnt=%h yv=%b want 04/1", gnt, y_valid);
        end
        tick();
        req = 8'h81;
        #1;
        n_cmp++; if (y_valid !== 1'b0 || y !== 1'b0) begin
            n_bad++; $display("FAIL ed_drop: yv=%b y=%b want 0/0", y_valid, y);
        end
        tick();
        n_cmp++; if (gnt !== 8'h80 || s !== 3'd7 || busy !== 1'b1) begin
            n_bad++; $display("FAIL ed_ch7: gnt=%h s=%0d busy=%b want 80/7/1", gnt, s, busy);
        end
        for (int b = 0; b < MAXB; b++) tick();
        n_cmp++; if (gnt !== 8'h01) begin n_bad++; $display("FAIL ed_ch0: gnt=%h want 01", gnt); end
    endtask

    task automatic test_sole_en();
        do_reset();
        en = 1'b1; y_ready = 1'b1; req = 8'h10;
        tick();
        for (int b = 0; b < 3 * MAXB + 1; b++) begin
            n_cmp++; if (gnt !== 8'h10 || busy !== 1'b1 || y_valid !== 1'b1) begin
                n_bad++; $display("FAIL sole_b%0d: gnt=%h busy=%b yv=%b want 10/1/1", b, gnt, busy, y_valid);
            end
            tick();
        end
        en = 1'b0;
        for (int b = 0; b < MAXB - 1; b++) begin
            n_cmp++; if (gnt !== 8'h10 || busy !== 1'b1) begin
                n_bad++; $display("FAIL sole_en0_b%0d: gnt=%h busy=%b want 10/1", b, gnt, busy);
            end
            tick();
        end
        n_cmp++; if (busy !== 1'b0 || gnt !== 8'h00 || y_valid !== 1'b0) begin
            n_bad++; $display("FAIL sole_idle: busy=%b gnt=%h yv=%b want 0/00/0", busy, gnt, y_valid);
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sole_stay_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_random();
        do_reset();
        req = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            y_ready = ($urandom_range(0, 2) != 0);
            i       = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                rst = 1'b0;
            end
            #1;
            n_cmp++; if (gnt !== exp_gnt() || busy !== m_busy) begin
                n_bad++; $display("FAIL rnd_gnt_c%0d: gnt=%h busy=%b want %h/%b", c, gnt, busy, exp_gnt(), m_busy);
            end
            n_cmp++; if (s !== 3'(m_ch)) begin
                n_bad++; $display("FAIL rnd_s_c%0d: got %0d want %0d", c, s, m_ch);
            end
            n_cmp++; if (y_valid !== exp_yv() || y !== exp_y()) begin
                n_bad++; $display("FAIL rnd_y_c%0d: yv=%b y=%b want %b/%b", c, y_valid, y, exp_yv(), exp_y());
            end
            n_cmp++; if ($countones(gnt) > 1) begin
                n_bad++; $display("FAIL rnd_onehot_c%0d: gnt=%h want zero or one-hot", c, gnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_reset_mid_busy();
        test_rotation();
        test_backpressure();
        test_early_drop();
        test_sole_en();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
